// File: rtl/keypad_scan_fsm_if.sv
// Keypad scanner bus: the keypad row lines in, plus the column drive and accepted-key strobe out.
// WE_send is a one-cycle valid with no ready; cols and synchrows are stable while it is high.
interface keypad_scan_fsm_if;
  logic [3:0] rows_raw;
  logic [3:0] cols;
  logic [3:0] synchrows;
  logic       WE_send;
  logic       key_held;
  logic [2:0] state;

  modport master (
    input  rows_raw,
    output cols,
    output synchrows,
    output WE_send,
    output key_held,
    output state
  );

  modport slave (
    output rows_raw,
    input  cols,
    input  synchrows,
    input  WE_send,
    input  key_held,
    input  state
  );
endinterface

// File: rtl/keypad_scan_fsm.sv
// 4x4 keypad scanner: walks the active-low columns, debounces press and release on the
// synchronized rows, and emits one WE_send strobe with {cols, synchrows} per accepted key.
module keypad_scan_fsm #(
  parameter int SCAN_DIV        = 4096,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic                clk,
  input  logic                reset,
  keypad_scan_fsm_if.master   bus
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    SCAN     = 3'd0,
    DEBOUNCE = 3'd1,
    SEND     = 3'd2,
    HOLD     = 3'd3,
    REL_DEB  = 3'd4
  } state_t;

  state_t        state;
  logic [3:0]    rows_meta;
  logic [3:0]    r_sync;
  logic [3:0]    cap;
  logic [3:0]    cols;
  logic [3:0]    synchrows;
  logic          we_send;
  logic          key_held;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] deb_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      rows_meta <= 4'b1111;
      r_sync    <= 4'b1111;
      cap       <= 4'b1111;
      cols      <= 4'b1110;
      synchrows <= 4'b1111;
      we_send   <= 1'b0;
      key_held  <= 1'b0;
      scan_cnt  <= '0;
      deb_cnt   <= '0;
    end else begin
      rows_meta <= bus.rows_raw;
      r_sync    <= rows_meta;
      we_send   <= 1'b0;
      case (state)
        SCAN: begin
          // Rows are only looked at on the tick so they have settled after the column change.
          if (scan_cnt == SCAN_LAST) begin
            if (r_sync == 4'b1111) begin
              cols     <= {cols[2:0], cols[3]};
              scan_cnt <= '0;
            end else begin
              cap     <= r_sync;
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (r_sync != cap) begin
            scan_cnt <= '0;
            state    <= SCAN;
          end else if (deb_cnt == DEB_LAST) begin
            synchrows <= cap;
            we_send   <= 1'b1;
            key_held  <= 1'b1;
            state     <= SEND;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        SEND: begin
          state <= HOLD;
        end
        HOLD: begin
          if (r_sync == 4'b1111) begin
            deb_cnt <= '0;
            state   <= REL_DEB;
          end
        end
        REL_DEB: begin
          if (r_sync != 4'b1111) begin
            state <= HOLD;
          end else if (deb_cnt == DEB_LAST) begin
            key_held <= 1'b0;
            cols     <= {cols[2:0], cols[3]};
            scan_cnt <= '0;
            state    <= SCAN;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: begin
          state <= SCAN;
        end
      endcase
    end
  end

  assign bus.cols      = cols;
  assign bus.synchrows = synchrows;
  assign bus.WE_send   = we_send;
  assign bus.key_held  = key_held;
  assign bus.state     = state;

endmodule
